dcache_ctrl: RTL and testbench

- Requester-side controller for main_memory: a direct-mapped, write-through, no-write-allocate data cache between the RISC-V core's load/store port and main memory.
- Drives main memory's address, write data, mem_read and mem_write, and consumes its read_data, ready_to_read and finished_writing handshake.
- Stalls the core while a memory transaction is outstanding.

---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_array.sv | 53 +++++
 rtl/dcache_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache controller.
// Holds the default geometry, the widths derived from it, the wait counter
// width and the controller state encoding.
package dcache_pkg;

    localparam int ADD_WIDTH_DEF   = 10;
    localparam int DATA_WIDTH_DEF  = 32;
    localparam int INDEX_WIDTH_DEF = 4;

    localparam int TAG_WIDTH = ADD_WIDTH_DEF - INDEX_WIDTH_DEF;
    localparam int LINES     = 1 << INDEX_WIDTH_DEF;

    // The wait counter only has to distinguish "first cycle" from "later",
    // so two bits saturating at 3 are plenty.
    localparam int                    WCNT_WIDTH = 2;
    localparam logic [WCNT_WIDTH-1:0] WCNT_MAX   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped cache: one word per line.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears valid bits)
//   rd_index_i          lookup index (asynchronous read)
//   rd_valid_o/_tag_o/_data_o  contents of the addressed line
//   wr_en_i             write strobe; sets valid and stores tag and data
//   wr_index_i/_tag_i/_data_i  line to write
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = INDEX_WIDTH_DEF,
    parameter int TAG_W   = TAG_WIDTH,
    parameter int DATA_W  = DATA_WIDTH_DEF,
    parameter int N_LINES = LINES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [N_LINES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [N_LINES];
    logic [DATA_W-1:0]  data_q [N_LINES];

    // Valid bits: cleared by reset so every line misses afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {N_LINES{1'b0}};
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data storage: contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller sitting
// between the core's load/store port and main memory.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cpu_addr, cpu_wdata           core word address and store data
//   cpu_read, cpu_write           core requests, held while cpu_stall=1
//   cpu_rdata, cpu_stall          load data and stall back to the core
//   mem_add, mem_write_data       main memory address / write data (registered)
//   mem_read, mem_write           main memory strobes, held for a whole transaction
//   mem_read_data                 main memory read data
//   mem_ready_to_read             main memory read-done flag
//   mem_finished_writing          main memory write-done flag
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADD_WIDTH   = ADD_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADD_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic [ADD_WIDTH-1:0]  mem_add,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_ready_to_read,
    input  logic                  mem_finished_writing
);

    localparam int TAG_W = ADD_WIDTH - INDEX_WIDTH;

    state_e                  state_q, state_d;
    logic [WCNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    hit_q, hit_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADD_WIDTH-1:0]    mem_add_q, mem_add_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;

    logic                    line_valid;
    logic [TAG_W-1:0]        line_tag;
    logic [DATA_WIDTH-1:0]   line_data;
    logic                    lookup_hit;
    logic                    arr_we;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [WCNT_WIDTH-1:0]   wait_inc;
    logic                    stall_c;
    logic [DATA_WIDTH-1:0]   rdata_c;

    // Lookups only happen in IDLE against the live core address; all writes
    // (fills and store hits) target the latched transaction address.
    dcache_array #(
        .INDEX_W (INDEX_WIDTH),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_WIDTH),
        .N_LINES (1 << INDEX_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (cpu_addr[INDEX_WIDTH-1:0]),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (arr_we),
        .wr_index_i (mem_add_q[INDEX_WIDTH-1:0]),
        .wr_tag_i   (mem_add_q[ADD_WIDTH-1:INDEX_WIDTH]),
        .wr_data_i  (arr_wdata)
    );

    assign lookup_hit = line_valid && (line_tag == cpu_addr[ADD_WIDTH-1:INDEX_WIDTH]);
    assign wait_inc   = (wait_cnt_q == WCNT_MAX) ? wait_cnt_q : (wait_cnt_q + 2'd1);

    // State register and transaction latches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= {WCNT_WIDTH{1'b0}};
            hit_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_add_q   <= {ADD_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            cpu_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            hit_q       <= hit_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_add_q   <= mem_add_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Next-state, handshake and core-facing outputs.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        hit_d       = hit_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_add_d   = mem_add_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        arr_we      = 1'b0;
        arr_wdata   = mem_wdata_q;
        stall_c     = 1'b0;
        rdata_c     = cpu_rdata_q;

        case (state_q)
            IDLE: begin
                wait_cnt_d = {WCNT_WIDTH{1'b0}};
                if (cpu_write) begin
                    // Stores always go to memory; the hit flag decides later
                    // whether the cached copy is refreshed.
                    stall_c     = 1'b1;
                    hit_d       = lookup_hit;
                    mem_write_d = 1'b1;
                    mem_add_d   = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    state_d     = WR_WAIT;
                end else if (cpu_read) begin
                    if (lookup_hit) begin
                        rdata_c = line_data;
                    end else begin
                        stall_c    = 1'b1;
                        mem_read_d = 1'b1;
                        mem_add_d  = cpu_addr;
                        state_d    = RD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                // Memory's done flag is sticky and its phase counter free
                // running, so a flag seen in the first wait cycle is stale.
                stall_c    = 1'b1;
                wait_cnt_d = wait_inc;
                if (mem_ready_to_read && (wait_cnt_q != {WCNT_WIDTH{1'b0}})) begin
                    arr_we      = 1'b1;
                    arr_wdata   = mem_read_data;
                    cpu_rdata_d = mem_read_data;
                    mem_read_d  = 1'b0;
                    state_d     = RESP;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            WR_WAIT: begin
                stall_c    = 1'b1;
                wait_cnt_d = wait_inc;
                if (mem_finished_writing && (wait_cnt_q != {WCNT_WIDTH{1'b0}})) begin
                    // No write allocate: only an already-present line is updated.
                    arr_we      = hit_q;
                    arr_wdata   = mem_wdata_q;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                end else begin
                    state_d = WR_WAIT;
                end
            end
            RESP: begin
                wait_cnt_d = {WCNT_WIDTH{1'b0}};
                state_d    = IDLE;
            end
            default: begin
                wait_cnt_d  = {WCNT_WIDTH{1'b0}};
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign cpu_stall      = stall_c;
    assign cpu_rdata      = rdata_c;
    assign mem_add        = mem_add_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl with a behavioural main memory model
// (free-running 2-bit phase counter, sticky done flags).
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [9:0]  mem_add;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic        mem_ready_to_read;
    logic        mem_finished_writing;

    dcache_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .cpu_addr             (cpu_addr),
        .cpu_wdata            (cpu_wdata),
        .cpu_read             (cpu_read),
        .cpu_write            (cpu_write),
        .cpu_rdata            (cpu_rdata),
        .cpu_stall            (cpu_stall),
        .mem_add              (mem_add),
        .mem_write_data       (mem_write_data),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_read_data        (mem_read_data),
        .mem_ready_to_read    (mem_ready_to_read),
        .mem_finished_writing (mem_finished_writing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Main memory model: the operation lands on the edge leaving phase 1,
    // the matching done flag clears on the edge leaving phase 3 and is
    // otherwise sticky; the phase counter is never reset.
    logic [31:0] mem [1024];
    logic [1:0]  mcnt;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h025] = 32'hDEADBEEF;
        mem[10'h035] = 32'hCAFEF00D;
        mcnt = 2'd3;
        mem_ready_to_read    = 1'b0;
        mem_finished_writing = 1'b0;
        mem_read_data        = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_read) begin
                if (mcnt == 2'd3) mem_ready_to_read <= 1'b0;
                if (mcnt == 2'd1) begin
                    mem_ready_to_read <= 1'b1;
                    mem_read_data     <= mem[mem_add];
                end
                mcnt <= mcnt + 2'd1;
            end else if (mem_write) begin
                if (mcnt == 2'd3) mem_finished_writing <= 1'b0;
                if (mcnt == 2'd1) begin
                    mem_finished_writing <= 1'b1;
                    mem[mem_add]         <= mem_write_data;
                end
                mcnt <= mcnt + 2'd1;
            end
        end
    end

    typedef struct {
        logic        is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
        int          smin;
        int          smax;
        int          mcyc;   // expected memory-strobe cycles, -1 = don't care
    } exp_t;

    exp_t        sb[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          stall_n      = 0;
    int          rd_n         = 0;
    int          wr_n         = 0;
    int          excl_bad     = 0;
    logic [9:0]  add_seen     = 10'h0;
    logic [31:0] wd_seen      = 32'h0;
    logic        unstable     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests_run++;
        if (act < lo || act > hi) begin
            tests_failed++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: accumulates per-request observations and, whenever the core
    // sees its request released, pops the scoreboard and compares.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_read && mem_write) excl_bad++;
            if (rst) begin
                stall_n = 0; rd_n = 0; wr_n = 0; unstable = 1'b0;
            end else if (cpu_read || cpu_write) begin
                if (mem_read || mem_write) begin
                    if (rd_n + wr_n == 0) begin
                        add_seen = mem_add;
                        wd_seen  = mem_write_data;
                    end else if (mem_add != add_seen || (mem_write && mem_write_data != wd_seen)) begin
                        unstable = 1'b1;
                    end
                    if (mem_read)  rd_n++;
                    if (mem_write) wr_n++;
                end
                if (cpu_stall) begin
                    stall_n++;
                end else if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_response: actual=addr %h required=no response", cpu_addr);
                end else begin
                    e = sb.pop_front();
                    check("kind", 32'(cpu_write), 32'(e.is_wr));
                    if (!e.is_wr) check("rdata", cpu_rdata, e.data);
                    check_range("stall_cycles", stall_n, e.smin, e.smax);
                    if (e.mcyc >= 0) begin
                        check("mem_read_cycles", 32'(rd_n), e.is_wr ? 32'd0 : 32'(e.mcyc));
                        check("mem_write_cycles", 32'(wr_n), e.is_wr ? 32'(e.mcyc) : 32'd0);
                    end
                    if (rd_n + wr_n > 0) begin
                        check("mem_add", 32'(add_seen), 32'(e.addr));
                        check("mem_stable", 32'(unstable), 32'd0);
                        if (e.is_wr) check("mem_write_data", wd_seen, e.data);
                    end
                    stall_n = 0; rd_n = 0; wr_n = 0; unstable = 1'b0;
                end
            end
        end
    endtask

    // Drive one request (called just after a rising edge), wait for release.
    task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d,
                         input int smin, input int smax, input int mc);
        bit done;
        sb.push_back('{wr, a, d, smin, smax, mc});
        cpu_write = wr;
        cpu_read  = !wr;
        cpu_addr  = a;
        cpu_wdata = wr ? d : 32'h0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout: actual=stalled addr %h required=release within 40 cycles", a);
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic stimulus();
        issue(1'b0, 10'h025, 32'hDEADBEEF, 5, 5, 4);   // cold miss
        issue(1'b0, 10'h025, 32'hDEADBEEF, 0, 0, 0);   // immediate hit
        issue(1'b0, 10'h035, 32'hCAFEF00D, 5, 5, 4);   // conflict, evicts 0x025
        issue(1'b0, 10'h025, 32'hDEADBEEF, 5, 5, 4);   // misses again
        issue(1'b1, 10'h025, 32'h12345678, 5, 5, 4);   // store hit, write-through
        issue(1'b0, 10'h025, 32'h12345678, 0, 0, 0);   // hit with new data
        issue(1'b1, 10'h100, 32'hA5A5A5A5, 5, 5, 4);   // store miss
        check("mem_0x100", mem[10'h100], 32'hA5A5A5A5);
        issue(1'b0, 10'h100, 32'hA5A5A5A5, 5, 5, 4);   // not allocated: miss
        issue(1'b0, 10'h035, 32'hCAFEF00D, 5, 5, 4);   // read miss ...
        issue(1'b1, 10'h035, 32'h0BADCAFE, 5, 5, 4);   // ... then store with stale write-done flag
        issue(1'b0, 10'h035, 32'h0BADCAFE, 0, 0, 0);   // store hit updated the line

        // Reset in the second RD_WAIT cycle of a read miss.
        cpu_read = 1'b1;
        cpu_addr = 10'h025;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rd2_mem_read", 32'(mem_read), 32'd1);
        rst      = 1'b1;
        cpu_read = 1'b0;
        #1;
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_mem_add", 32'(mem_add), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b0, 10'h025, 32'h12345678, 2, 5, -1);  // 1..4 wait cycles are legal
        issue(1'b0, 10'h035, 32'h0BADCAFE, 5, 5, 4);   // invalidated by reset
        issue(1'b0, 10'h100, 32'hA5A5A5A5, 5, 5, 4);
        issue(1'b0, 10'h100, 32'hA5A5A5A5, 0, 0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 10'h0;
        cpu_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cpu_stall", 32'(cpu_stall), 32'd0);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_mem_add", 32'(mem_add), 32'd0);
        check("reset_mem_write_data", mem_write_data, 32'd0);
        check("reset_cpu_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        fork
            monitor_loop();
            stimulus();
        join_any
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("mem_strobe_exclusive", 32'(excl_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
